des_dec_key_sched: RTL and testbench
====================================

# des_dec_key_sched

Iterative DES key-schedule generator that streams the 16 round subkeys in decryption order, K16 first and K1 last. It performs PC-1 once and then right-rotates the C/D halves. Each subkey is selected through PC-2.
- Upstream: accepts one 64-bit key per job.
- Downstream: feeds the Feistel round datapath, one subkey per round handshake.
- Companion to the existing F-function/S-box datapath when that datapath runs decryption.

## Interface
Parameters:
- none

Ports:
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  synchronous, active-high reset
- key_valid  input  1  key offered
- key_ready  output  1  block can accept a key; high only in IDLE
- key  input  64  DES key; key[63] = DES bit 1; parity bits are ignored
- sk_valid  output  1  subkey output valid
- sk_ready  input  1  downstream accepts the subkey
- subkey  output  48  PC-2 output; subkey[47] = PC-2 bit 1
- sk_round  output  4  round number of the subkey minus 1 (15 for K16 … 0 for K1)
- sk_last  output  1  high with the final subkey of the job

## Operation
- Two-state FSM: IDLE and EMIT.
- IDLE:
  - key_ready=1, sk_valid=0.
  - On key_valid&&key_ready: load {C,D} = PC-1(key) (28+28 bits), set sk_round=15, go to EMIT.
- Why K16 comes first: the total left shift across all rounds is 28, so C16D16 = C0D0, and K16 = PC-2(C0D0).
- EMIT:
  - subkey is PC-2 of the registered C/D.
  - sk_valid=1; sk_last = (sk_round==0).
  - On sk_valid&&sk_ready with sk_round=i-1 (emitting Ki, i>1): rotate C and D right by shift[i], then decrement sk_round.
  - shift[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - On acceptance with sk_last=1: return to IDLE; C/D need not be cleared.
- Stall: while sk_valid=1 && sk_ready=0, subkey, sk_round and sk_last hold stable.
- Keys: key_valid during EMIT is ignored and not queued. Key contents are not checked (weak keys, parity).
- Outputs:
  - subkey is registered, or derived purely from registered C/D by fixed wiring.
  - There is no combinational path from sk_ready to sk_valid or subkey.

## Timing
- Reset values: key_ready=1, sk_valid=0, sk_last=0, sk_round=0, subkey=0.
  - subkey is forced to 0 while sk_valid=0.
- Latency: key accepted at edge N gives sk_valid=1 with K16 from cycle N+1.
- Throughput:
  - With sk_ready held high, one subkey per cycle: K16..K1 in cycles N+1..N+16.
  - key_ready rises at N+17, so the minimum job period is 17 cycles.
- Handshake: a subkey transfers on a rising edge where sk_valid&&sk_ready.
- Rotation width rule: each rotation is within its 28-bit half. A rotate right by 2 moves bits [1:0] to [27:26].
- Reset mid-job: rst=1 on any edge aborts the job. Outputs return to reset values on the next cycle; no partial subkeys follow.
- rst has priority over any simultaneous handshake.

## Configuration
- Macro: DES_KS_ENC_MODE_EN.
- When defined:
  - Adds input port `enc` (1 bit), sampled with the key.
  - enc=1 gives encryption order: apply the shift[1] left rotation of PC-1(key) at load. K1 is emitted first with sk_round=0.
  - Then rotate left by shift[i+1] after each accepted Ki; sk_round increments; sk_last when sk_round==15.
  - enc=0 behaves exactly as the decrypt-only block.
- When undefined: no `enc` port; decryption order only. The logic is identical to the enc=0 case.

## Test plan
- Reset, then key=64'h133457799BBCDFF1 with sk_ready=1:
  - cycle +1: subkey=48'hCB3D8B0E17F5 (K16), sk_round=15.
  - next cycle: 48'hBF918D3D3F0A (K15).
  - cycle +15: 48'h79AED9DBC9E5 (K2).
  - cycle +16: 48'h1B02EFFC7072 (K1), sk_last=1.
- Same key with sk_ready toggled pseudo-randomly: all 16 subkeys appear in the same order, each stable while stalled; key_ready stays 0 until K1 is accepted.
- key_valid pulsed with a different key during EMIT: ignored; the stream continues with the original key's subkeys.
- rst asserted after K10 is accepted: next cycle sk_valid=0, key_ready=1. A new key then starts from K16 correctly.
- Back-to-back jobs with key_valid held high: second key accepted on the cycle after K1 transfers; its K16 appears one cycle later.
- With DES_KS_ENC_MODE_EN, enc=1 and the same key: first subkey is 48'h1B02EFFC7072 (sk_round=0), last is 48'hCB3D8B0E17F5 with sk_last=1.

Source files
------------

// File: rtl/des_dec_key_sched.sv
// rtl/des_dec_key_sched.sv - iterative DES key schedule streaming K16..K1 for decryption
// Define DES_KS_ENC_MODE_EN to add the enc port and an encryption-order (K1..K16) mode.
module des_dec_key_sched (
   input  logic        clk,
   input  logic        rst,
   input  logic        key_valid,
   output logic        key_ready,
   input  logic [63:0] key,
`ifdef DES_KS_ENC_MODE_EN
   input  logic        enc,
`endif
   output logic        sk_valid,
   input  logic        sk_ready,
   output logic [47:0] subkey,
   output logic [3:0]  sk_round,
   output logic        sk_last
);

   typedef enum logic {IDLE, EMIT} state_t;

   localparam int PC1_TBL [0:55] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };

   localparam int PC2_TBL [0:47] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };

   // Bit r set where the DES schedule shifts by one in round r+1 (rounds 1, 2, 9, 16).
   localparam logic [15:0] ONE_SHIFT = 16'h8103;

   function automatic logic [55:0] pc1(input logic [63:0] k);
      logic [55:0] r;
      r = '0;
      for (logic [5:0] j = 6'd0; j < 6'd56; j++) begin
         r[6'd55 - j] = k[6'(64 - PC1_TBL[j])];
      end
      return r;
   endfunction

   function automatic logic [47:0] pc2(input logic [55:0] cd);
      logic [47:0] r;
      r = '0;
      for (logic [5:0] j = 6'd0; j < 6'd48; j++) begin
         r[6'd47 - j] = cd[6'(56 - PC2_TBL[j])];
      end
      return r;
   endfunction

   // Rotations stay inside each 28-bit half; two=1 selects a double step.
   function automatic logic [55:0] rot_r(input logic [55:0] cd, input logic two);
      logic [27:0] c;
      logic [27:0] d;
      c = cd[55:28];
      d = cd[27:0];
      if (two) begin
         c = {c[1:0], c[27:2]};
         d = {d[1:0], d[27:2]};
      end else begin
         c = {c[0], c[27:1]};
         d = {d[0], d[27:1]};
      end
      return {c, d};
   endfunction

   function automatic logic [55:0] rot_l(input logic [55:0] cd, input logic two);
      logic [27:0] c;
      logic [27:0] d;
      c = cd[55:28];
      d = cd[27:0];
      if (two) begin
         c = {c[25:0], c[27:26]};
         d = {d[25:0], d[27:26]};
      end else begin
         c = {c[26:0], c[27]};
         d = {d[26:0], d[27]};
      end
      return {c, d};
   endfunction

   state_t      state_q, state_d;
   logic [55:0] cd_q, cd_d;
   logic [3:0]  round_q, round_d;
   logic        enc_sel;
   logic        last_w;

`ifdef DES_KS_ENC_MODE_EN
   logic        enc_q, enc_d;
   assign enc_sel = enc_q;
`else
   assign enc_sel = 1'b0;
`endif

   assign last_w = enc_sel ? (round_q == 4'd15) : (round_q == 4'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cd_q    <= '0;
         round_q <= '0;
`ifdef DES_KS_ENC_MODE_EN
         enc_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cd_q    <= cd_d;
         round_q <= round_d;
`ifdef DES_KS_ENC_MODE_EN
         enc_q   <= enc_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      cd_d      = cd_q;
      round_d   = round_q;
`ifdef DES_KS_ENC_MODE_EN
      enc_d     = enc_q;
`endif
      key_ready = 1'b0;
      sk_valid  = 1'b0;
      sk_last   = 1'b0;
      sk_round  = round_q;
      subkey    = '0;

      case (state_q)
         IDLE: begin
            key_ready = 1'b1;
            if (key_valid) begin
               cd_d    = pc1(key);
               round_d = 4'd15;
               state_d = EMIT;
`ifdef DES_KS_ENC_MODE_EN
               enc_d   = enc;
               if (enc) begin
                  cd_d    = rot_l(pc1(key), 1'b0);
                  round_d = 4'd0;
               end
`endif
            end
         end
         EMIT: begin
            sk_valid = 1'b1;
            sk_last  = last_w;
            subkey   = pc2(cd_q);
            if (sk_ready) begin
               if (last_w) begin
                  state_d = IDLE;
                  round_d = 4'd0;
               end else if (enc_sel) begin
                  cd_d    = rot_l(cd_q, ~ONE_SHIFT[round_q + 4'd1]);
                  round_d = round_q + 4'd1;
               end else begin
                  cd_d    = rot_r(cd_q, ~ONE_SHIFT[round_q]);
                  round_d = round_q - 4'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_des_dec_key_sched.sv
// tb/tb_des_dec_key_sched.sv - randomized bench for des_dec_key_sched against a forward-order DES schedule model
module tb_des_dec_key_sched;

   localparam logic [63:0] TV_KEY = 64'h133457799BBCDFF1;

   localparam int PC1 [0:55] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };

   localparam int PC2 [0:47] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };

   logic        clk = 1'b0;
   logic        rst;
   logic        key_valid;
   logic        key_ready;
   logic [63:0] key;
   logic        sk_valid;
   logic        sk_ready;
   logic [47:0] subkey;
   logic [3:0]  sk_round;
   logic        sk_last;
`ifdef DES_KS_ENC_MODE_EN
   logic        enc;
`endif

   int total = 0;
   int bad   = 0;

   // ref_ks[i] holds K(i+1), computed in the textbook forward direction.
   logic [47:0] ref_ks [0:15];

   always #5 clk = ~clk;

   des_dec_key_sched dut (
      .clk       (clk),
      .rst       (rst),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .key       (key),
`ifdef DES_KS_ENC_MODE_EN
      .enc       (enc),
`endif
      .sk_valid  (sk_valid),
      .sk_ready  (sk_ready),
      .subkey    (subkey),
      .sk_round  (sk_round),
      .sk_last   (sk_last)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic int shift_of(input int rnd);
      return (rnd == 1 || rnd == 2 || rnd == 9 || rnd == 16) ? 1 : 2;
   endfunction

   task automatic build_ref(input logic [63:0] k);
      logic [27:0] c;
      logic [27:0] d;
      logic [55:0] cd;
      logic [47:0] ks;
      c  = '0;
      d  = '0;
      ks = '0;
      for (int j = 0; j < 28; j++) begin
         c[5'(27 - j)] = k[6'(64 - PC1[6'(j)])];
         d[5'(27 - j)] = k[6'(64 - PC1[6'(28 + j)])];
      end
      for (int i = 1; i <= 16; i++) begin
         for (int s = 0; s < shift_of(i); s++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
         end
         cd = {c, d};
         for (int j = 0; j < 48; j++) ks[6'(47 - j)] = cd[6'(56 - PC2[6'(j)])];
         ref_ks[4'(i - 1)] = ks;
      end
   endtask

   task automatic run_job(input logic [63:0] k, input bit enc_mode, input bit rand_ready,
                          input bit noise, input bit hold_next, input logic [63:0] next_k,
                          input int stop_after);
      int          idx;
      int          cyc;
      logic [3:0]  exp_rd;
      build_ref(k);
      check("key_ready_idle", 64'(key_ready), 64'd1);
      key       = k;
      key_valid = 1'b1;
`ifdef DES_KS_ENC_MODE_EN
      enc       = enc_mode;
`endif
      @(posedge clk); #1;
      key_valid = hold_next;
      key       = hold_next ? next_k : k;
      idx = 0;
      cyc = 0;
      while (idx < stop_after && cyc < 400) begin
         sk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (noise) begin
            key_valid = 1'($urandom_range(0, 1));
            key       = {$urandom(), $urandom()};
         end
         exp_rd = enc_mode ? 4'(idx) : 4'(15 - idx);
         check("sk_valid", 64'(sk_valid), 64'd1);
         check("key_ready_busy", 64'(key_ready), 64'd0);
         check("subkey", 64'(subkey), 64'(ref_ks[exp_rd]));
         check("sk_round", 64'(sk_round), 64'(exp_rd));
         check("sk_last", 64'(sk_last), 64'(idx == 15));
         if (k == TV_KEY) begin
            case (exp_rd)
               4'd15: check("tv_k16", 64'(subkey), 64'h0000CB3D8B0E17F5);
               4'd14: check("tv_k15", 64'(subkey), 64'h0000BF918D3D3F0A);
               4'd1:  check("tv_k2",  64'(subkey), 64'h000079AED9DBC9E5);
               4'd0:  check("tv_k1",  64'(subkey), 64'h00001B02EFFC7072);
               default: ;
            endcase
         end
         if (sk_ready) idx++;
         @(posedge clk); #1;
         cyc++;
      end
      if (idx < stop_after) check("timeout", 64'(idx), 64'(stop_after));
      if (!hold_next) key_valid = 1'b0;
      sk_ready = 1'b0;
      if (stop_after == 16) begin
         check("done_sk_valid", 64'(sk_valid), 64'd0);
         check("done_key_ready", 64'(key_ready), 64'd1);
         check("done_subkey", 64'(subkey), 64'd0);
         check("done_sk_last", 64'(sk_last), 64'd0);
      end
   endtask

   initial begin
      logic [63:0] k2;
      rst       = 1'b1;
      key_valid = 1'b0;
      sk_ready  = 1'b0;
      key       = '0;
`ifdef DES_KS_ENC_MODE_EN
      enc       = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      check("rst_key_ready", 64'(key_ready), 64'd1);
      check("rst_sk_valid", 64'(sk_valid), 64'd0);
      check("rst_sk_last", 64'(sk_last), 64'd0);
      check("rst_sk_round", 64'(sk_round), 64'd0);
      check("rst_subkey", 64'(subkey), 64'd0);
      rst = 1'b0;

      run_job(TV_KEY, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 16);
      run_job(TV_KEY, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 16);
      run_job(TV_KEY, 1'b0, 1'b1, 1'b1, 1'b0, 64'd0, 16);

      // Abort after K10 has been accepted (K16..K10 is seven transfers).
      run_job(TV_KEY, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0, 7);
      rst = 1'b1;
      @(posedge clk); #1;
      check("abort_sk_valid", 64'(sk_valid), 64'd0);
      check("abort_key_ready", 64'(key_ready), 64'd1);
      check("abort_subkey", 64'(subkey), 64'd0);
      check("abort_sk_round", 64'(sk_round), 64'd0);
      rst = 1'b0;
      run_job(TV_KEY, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 16);

      k2 = {$urandom(), $urandom()};
      run_job({$urandom(), $urandom()}, 1'b0, 1'b0, 1'b0, 1'b1, k2, 16);
      run_job(k2, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 16);

      for (int n = 0; n < 6; n++) begin
         run_job({$urandom(), $urandom()}, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 64'd0, 16);
      end

`ifdef DES_KS_ENC_MODE_EN
      run_job(TV_KEY, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 16);
      run_job(TV_KEY, 1'b1, 1'b1, 1'b1, 1'b0, 64'd0, 16);
      for (int n = 0; n < 4; n++) begin
         run_job({$urandom(), $urandom()}, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0, 64'd0, 16);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
